// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Front end for the small control FSMs. Each of N raw push-button or switch
//   inputs is synchronised into clk, debounced, and turned into a clean level
//   plus one-clock rise/fall pulses. The channels are independent; each one is
//   a single instance of input_conditioner_ch.
//
// Parameters
//   N          number of input channels
//   DB_CYCLES  number of consecutive qualified samples a new value must hold
//              before it is accepted (1..255)
//
// Ports
//   clk    system clock; all state updates on its rising edge
//   reset  asynchronous, active-low reset
//   tick   sample enable for the debounce counters (tie to 1 for per-clock)
//   raw    [N]  unsynchronised inputs
//   level  [N]  debounced, synchronised level
//   rise   [N]  one-clock pulse on the edge where level goes 0->1
//   fall   [N]  one-clock pulse on the edge where level goes 1->0
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// input_conditioner_ch
//   A single channel: two-flop synchroniser followed by a saturating debounce
//   counter. Every output is a flop, so nothing combinational leads from raw to
//   the outputs.
//
// Ports
//   clk, reset, tick  as in the top level
//   raw               one raw input bit
//   level, rise, fall the conditioned outputs for this channel
// -----------------------------------------------------------------------------
module input_conditioner_ch #(
   parameter int DB_CYCLES = 4,
   parameter int CW        = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   // The counter only ever reaches DB_CYCLES-1. Reaching that value with a
   // qualified sample that still differs means the new value is accepted, so
   // the counter cannot wrap.
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   // Synchroniser. It is kept free of logic so both flops can be placed as a
   // metastability pair.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Debounce. If s2 agrees with level at any point, the count is discarded
   // regardless of tick, so a bounce gets no partial credit. The pulses are
   // single-cycle because they default to 0 on every edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (s2 == level) begin
            cnt <= '0;
         end else if (!tick) begin
            cnt <= cnt;
         end else if (cnt == CNT_MAX) begin
            level <= s2;
            cnt   <= '0;
            rise  <= s2;
            fall  <= ~s2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

module input_conditioner #(
   parameter int N         = 2,
   parameter int DB_CYCLES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tick,
   input  logic [N-1:0] raw,
   output logic [N-1:0] level,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall
);

   // The counter is ceil(log2(DB_CYCLES)) bits wide. When DB_CYCLES=1 that
   // evaluates to 0, so the width is forced to at least 1 bit.
   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   for (genvar i = 0; i < N; i++) begin : g_ch
      input_conditioner_ch #(
         .DB_CYCLES (DB_CYCLES),
         .CW        (CW)
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .tick  (tick),
         .raw   (raw[i]),
         .level (level[i]),
         .rise  (rise[i]),
         .fall  (fall[i])
      );
   end

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//   Self-checking bench for input_conditioner. The main DUT uses N=2 and
//   DB_CYCLES=4. A second instance with DB_CYCLES=1 shares the same stimulus
//   and covers the shortest latency. At each edge the expected {level,rise,
//   fall} is pushed to a queue while stimulus is driven, then popped and
//   compared 1ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

   localparam int N  = 2;
   localparam int DB = 4;

   logic         clk;
   logic         reset;
   logic         tick;
   logic [N-1:0] raw;
   logic [N-1:0] level, rise, fall;
   logic [N-1:0] level1, rise1, fall1;

   logic [3*N-1:0] sbq[$];
   logic [3*N-1:0] exp_v;
   int             n_checks;
   int             n_fail;

   input_conditioner #(.N(N), .DB_CYCLES(DB)) dut (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .raw   (raw),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

   input_conditioner #(.N(N), .DB_CYCLES(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .raw   (raw),
      .level (level1),
      .rise  (rise1),
      .fall  (fall1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Holds reset for two edges with raw at r, then releases it on a falling
   // edge. The next rising edge is E1.
   task automatic do_reset(input logic [N-1:0] r);
      reset = 1'b0;
      raw   = r;
      tick  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      raw   = '0;
      tick  = 1'b1;
      #2;
      n_checks++;
      if ({level, rise, fall} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_async: got %b want %b", {level, rise, fall}, 6'b0);
      end
      raw = 2'b11;
      for (int e = 1; e <= 3; e++) begin
         sbq.push_back(6'b0);
         @(posedge clk); #1;
         exp_v = sbq.pop_front();
         n_checks++;
         if ({level, rise, fall} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_hold e%0d: got %b want %b", e, {level, rise, fall}, exp_v);
         end
      end
   endtask

   // raw=01 held through reset release: level[0] goes high at E6.
   task automatic test_rise();
      do_reset(2'b01);
      for (int e = 1; e <= 8; e++) begin
         sbq.push_back({(e >= 6) ? 2'b01 : 2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00});
         @(posedge clk); #1;
         exp_v = sbq.pop_front();
         n_checks++;
         if ({level, rise, fall} !== exp_v) begin
            n_fail++;
            $display("FAIL rise e%0d: got %b want %b", e, {level, rise, fall}, exp_v);
         end
      end
   endtask

   // raw[0] is high for 3 clocks. That is too short to be accepted, and the
   // counter must return to 0: the next real change sees the full latency.
   task automatic test_glitch();
      do_reset(2'b00);
      for (int e = 1; e <= 6; e++) begin
         raw = (e <= 3) ? 2'b01 : 2'b00;
         sbq.push_back(6'b0);
         @(posedge clk); #1;
         exp_v = sbq.pop_front();
         n_checks++;
         if ({level, rise, fall} !== exp_v) begin
            n_fail++;
            $display("FAIL glitch e%0d: got %b want %b", e, {level, rise, fall}, exp_v);
         end
      end
      raw = 2'b01;
      for (int e = 1; e <= 7; e++) begin
         sbq.push_back({(e >= 6) ? 2'b01 : 2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00});
         @(posedge clk); #1;
         exp_v = sbq.pop_front();
         n_checks++;
         if ({level, rise, fall} !== exp_v) begin
            n_fail++;
            $display("FAIL glitch_recount e%0d: got %b want %b", e, {level, rise, fall}, exp_v);
         end
      end
   endtask

   task automatic test_fall();
      do_reset(2'b11);
      for (int e = 1; e <= 8; e++) begin
         sbq.push_back({(e >= 6) ? 2'b11 : 2'b00, (e == 6) ? 2'b11 : 2'b00, 2'b00});
         @(posedge clk); #1;
         exp_v = sbq.pop_front();
         n_checks++;
         if ({level, rise, fall} !== exp_v) begin
            n_fail++;
            $display("FAIL fall_setup e%0d: got %b want %b", e, {level, rise, fall}, exp_v);
         end
      end
      raw = 2'b00;
      for (int e = 1; e <= 8; e++) begin
         sbq.push_back({(e >= 6) ? 2'b00 : 2'b11, 2'b00, (e == 6) ? 2'b11 : 2'b00});
         @(posedge clk); #1;
         exp_v = sbq.pop_front();
         n_checks++;
         if ({level, rise, fall} !== exp_v) begin
            n_fail++;
            $display("FAIL fall e%0d: got %b want %b", e, {level, rise, fall}, exp_v);
         end
      end
   endtask

   // raw[1] follows 1,0,1,1,... The single 0 restarts the count, so level[1]
   // rises at E8, six edges after the final 0->1 at E3.
   task automatic test_bounce();
      do_reset(2'b00);
      for (int e = 1; e <= 10; e++) begin
         raw = (e == 2) ? 2'b00 : 2'b10;
         sbq.push_back({(e >= 8) ? 2'b10 : 2'b00, (e == 8) ? 2'b10 : 2'b00, 2'b00});
         @(posedge clk); #1;
         exp_v = sbq.pop_front();
         n_checks++;
         if ({level, rise, fall} !== exp_v) begin
            n_fail++;
            $display("FAIL bounce e%0d: got %b want %b", e, {level, rise, fall}, exp_v);
         end
      end
   endtask

   // tick is high on every third edge. s2 goes high at E2, so the qualified
   // samples fall on E3, E6, E9 and E12, and the fourth one is accepted.
   task automatic test_tick();
      do_reset(2'b00);
      raw = 2'b01;
      for (int e = 1; e <= 14; e++) begin
         tick = (e % 3 == 0);
         sbq.push_back({(e >= 12) ? 2'b01 : 2'b00, (e == 12) ? 2'b01 : 2'b00, 2'b00});
         @(posedge clk); #1;
         exp_v = sbq.pop_front();
         n_checks++;
         if ({level, rise, fall} !== exp_v) begin
            n_fail++;
            $display("FAIL tick e%0d: got %b want %b", e, {level, rise, fall}, exp_v);
         end
      end
      tick = 1'b1;
   endtask

   // Reset is asserted once cnt reaches 2. After release the whole latency has
   // to be paid again.
   task automatic test_reset_mid();
      do_reset(2'b00);
      raw = 2'b01;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int e = 0; e <= 2; e++) begin
         if (e > 0) begin
            @(posedge clk); #1;
         end else begin
            #1;
         end
         n_checks++;
         if ({level, rise, fall} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_hold e%0d: got %b want %b", e, {level, rise, fall}, 6'b0);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         sbq.push_back({(e >= 6) ? 2'b01 : 2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00});
         @(posedge clk); #1;
         exp_v = sbq.pop_front();
         n_checks++;
         if ({level, rise, fall} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid e%0d: got %b want %b", e, {level, rise, fall}, exp_v);
         end
      end
   endtask

   // DB_CYCLES=1: the rise is at E3, and the fall also takes 3 edges.
   task automatic test_db1();
      do_reset(2'b00);
      raw = 2'b01;
      for (int e = 1; e <= 4; e++) begin
         sbq.push_back({(e >= 3) ? 2'b01 : 2'b00, (e == 3) ? 2'b01 : 2'b00, 2'b00});
         @(posedge clk); #1;
         exp_v = sbq.pop_front();
         n_checks++;
         if ({level1, rise1, fall1} !== exp_v) begin
            n_fail++;
            $display("FAIL db1_rise e%0d: got %b want %b", e, {level1, rise1, fall1}, exp_v);
         end
      end
      raw = 2'b00;
      for (int e = 1; e <= 4; e++) begin
         sbq.push_back({(e >= 3) ? 2'b00 : 2'b01, 2'b00, (e == 3) ? 2'b01 : 2'b00});
         @(posedge clk); #1;
         exp_v = sbq.pop_front();
         n_checks++;
         if ({level1, rise1, fall1} !== exp_v) begin
            n_fail++;
            $display("FAIL db1_fall e%0d: got %b want %b", e, {level1, rise1, fall1}, exp_v);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      raw      = '0;
      tick     = 1'b1;
      test_reset();
      test_rise();
      test_glitch();
      test_fall();
      test_bounce();
      test_tick();
      test_reset_mid();
      test_db1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage for the small control FSMs: takes raw, asynchronous push-button/switch inputs and delivers clean, synchronised, debounced levels plus single-cycle edge pulses.
- Its level outputs drive the FSM input bus directly, e.g. level[1:0] -> SAB[1:0].
- One instance serves all N input channels; each channel is processed independently.

Parameters:
- N, 2, number of input channels
- DB_CYCLES, 4, consecutive qualified samples a new value must hold before it is accepted (legal range 1..255)

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- tick  input  1  sample-enable strobe for the debounce counters; tie to 1 for per-clock debounce
- raw  input  N  unsynchronised button/switch inputs
- level  output  N  debounced, synchronised level per channel
- rise  output  N  one-clock pulse when level[i] goes 0->1
- fall  output  N  one-clock pulse when level[i] goes 1->0

Behaviour:
- One clock domain, clk.
- Reset is asynchronous and active-low: reset=0 immediately clears s1, s2, level, rise, fall and every counter to 0, and they stay 0 while reset=0.
  - Reset mid-debounce discards the partial count.
- Synchroniser, per channel: two flops, raw -> s1 -> s2. No logic between the flops.
- Debounce counter, per channel:
  - Width = ceil(log2(DB_CYCLES)), minimum 1 bit.
  - The counter never exceeds DB_CYCLES-1, so it never wraps.
- Rules per channel on each rising edge of clk, evaluated in this priority:
  1. s2 == level: cnt <= 0; level unchanged. This happens regardless of tick.
  2. s2 != level and tick == 0: hold cnt and level.
  3. s2 != level, tick == 1, cnt == DB_CYCLES-1: level <= s2; cnt <= 0.
  4. s2 != level, tick == 1, otherwise: cnt <= cnt+1.
- Edge pulses:
  - rise[i] and fall[i] are registered and assert on the same edge on which level[i] changes.
  - Each is high for exactly one clock, then returns to 0.
  - rise and fall are never both high on one channel.
  - Channels may pulse in the same cycle.
- Latency with tick=1, raw changed before edge E1:
  - s1 is updated at E1 and s2 at E2.
  - level and the pulse update at edge E(DB_CYCLES+2). With default 4, that is the 6th edge.
- Glitch rejection: a raw pulse that keeps s2 differing from level for fewer than DB_CYCLES qualified samples produces no level change and no pulse. The counter returns to 0.
- Bounce: any return of s2 to the current level restarts the count from 0. There is no partial credit.
- DB_CYCLES=1: the first qualified sample accepts the change, so latency is 3 edges.
- After reset release with raw held at 1: level rises DB_CYCLES+2 edges later, with a rise pulse, because the reset level is 0.
- tick low for long stretches freezes counting but not the synchroniser.
- Outputs are registered with no combinational path from raw, so the block is safe to feed a downstream FSM directly.

Test Plan:
- Reset, then raw=2'b01 held from before E1, tick=1 -> level[0]=0 through E5; level=2'b01 and rise=2'b01 after E6; rise=0 after E7; level[1], fall stay 0.
- raw[0] high for 3 clocks then low (level=0) -> level[0], rise[0], fall[0] remain 0 throughout; internal cnt returns to 0.
- level=2'b11 stable, raw drops to 2'b00 -> after edge 6, level=2'b00 and fall=2'b11 for one clock, with rise=0.
- raw[1] bounce 1,0,1,1,1,1,... from level 0 -> the count restarts after the 0; level[1] rises 6 edges after the final 0->1 of raw[1] (DB_CYCLES=4).
- tick pulsed every 3rd clock, raw[0] 0->1 -> level[0] rises on the edge of the 4th tick-qualified sample after s2 goes high; no change on non-tick edges.
- Assert reset=0 midway through a count (cnt=2), release with raw still 1 -> all outputs read 0 during reset; after release, the full DB_CYCLES+2 latency is observed again before rise.
